// File: rtl/toggle_pack_pkg.sv
// Shared types and default sizes for the toggle sample packer.
package toggle_pack_pkg;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int unsigned DEF_WIDTH  = 8;   // samples per packed word
    localparam int unsigned DEF_EDGE_W = 16;  // rising-edge counter width
    localparam int unsigned DEF_DROP_W = 8;   // saturating drop counter width

endpackage : toggle_pack_pkg

// File: rtl/pack_fifo2.sv
// Two-entry word buffer with occupancy FSM; flags a drop when full and
// a push arrives without a pop.
// Ports:
//   clock, rst_n           clock and async active-low reset
//   push, push_data        completed word offered this cycle
//   out_ready              consumer accepts head word
//   out_valid, out_data    registered head of buffer (0 when empty)
//   drop_c                 combinational: push discarded this cycle
module pack_fifo2
    import toggle_pack_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             drop_c
);

    occ_e             state_q, state_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic [WIDTH-1:0] tail_q, tail_nxt;
    logic             pop_c;

    assign pop_c = out_valid && out_ready;

    // State, head/tail storage and registered valid
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCC_EMPTY;
            out_data  <= '0;
            tail_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            out_data  <= head_nxt;
            tail_q    <= tail_nxt;
            out_valid <= (state_nxt != OCC_EMPTY);
        end
    end

    // Next occupancy, head/tail movement and drop detection
    always_comb begin
        state_nxt = state_q;
        head_nxt  = out_data;
        tail_nxt  = tail_q;
        drop_c    = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (push) begin
                    state_nxt = OCC_ONE;
                    head_nxt  = push_data;
                end
            end
            OCC_ONE: begin
                if (push && pop_c) begin
                    head_nxt = push_data;
                end else if (push) begin
                    state_nxt = OCC_TWO;
                    tail_nxt  = push_data;
                end else if (pop_c) begin
                    state_nxt = OCC_EMPTY;
                    head_nxt  = '0;
                end
            end
            OCC_TWO: begin
                if (push && pop_c) begin
                    head_nxt = tail_q;
                    tail_nxt = push_data;
                end else if (pop_c) begin
                    state_nxt = OCC_ONE;
                    head_nxt  = tail_q;
                    tail_nxt  = '0;
                end else if (push) begin
                    drop_c = 1'b1;
                end
            end
            default: begin
                state_nxt = OCC_EMPTY;
                head_nxt  = '0;
                tail_nxt  = '0;
            end
        endcase
    end

endmodule : pack_fifo2

// File: rtl/toggle_sample_packer.sv
// Samples a single upstream bit on enabled cycles, packs WIDTH samples
// LSB-first into words, buffers them two deep on a valid/ready stream,
// counts rising edges of the sampled bit and tracks dropped words.
// Ports:
//   clock, rst_n           clock and async active-low reset
//   sample_in, sample_en   bit to sample and its qualifier
//   out_ready              consumer accepts head word
//   clear_ovf              clears overflow and drop_count
//   out_valid, out_data    output word stream
//   edge_count             rising edges seen on sampled bit (wrapping)
//   overflow, drop_count   sticky drop flag and saturating drop count
module toggle_sample_packer
    import toggle_pack_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned EDGE_W = DEF_EDGE_W,
    parameter int unsigned DROP_W = DEF_DROP_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              sample_in,
    input  logic              sample_en,
    input  logic              out_ready,
    input  logic              clear_ovf,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [EDGE_W-1:0] edge_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int unsigned FILL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [FILL_W-1:0] fill_q;
    logic [WIDTH-1:0]  partial_q;
    logic              prev_sample_q;
    logic              push_c;
    logic [WIDTH-1:0]  word_c;
    logic              drop_c;

    // Final sample goes straight into the word so it can push on this edge
    assign push_c = sample_en && (fill_q == FILL_W'(WIDTH - 1));
    assign word_c = {sample_in, partial_q[WIDTH-2:0]};

    // Sample packing
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            fill_q    <= '0;
            partial_q <= '0;
        end else if (sample_en) begin
            partial_q[fill_q] <= sample_in;
            fill_q            <= push_c ? '0 : fill_q + FILL_W'(1);
        end
    end

    // Rising-edge counter on the sampled stream
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample_q <= 1'b0;
            edge_count    <= '0;
        end else if (sample_en) begin
            prev_sample_q <= sample_in;
            if (!prev_sample_q && sample_in)
                edge_count <= edge_count + EDGE_W'(1);
        end
    end

    // Overflow flag and saturating drop count; a drop outranks clear_ovf
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop_c) begin
            overflow <= 1'b1;
            if (clear_ovf)
                drop_count <= DROP_W'(1);
            else if (drop_count != {DROP_W{1'b1}})
                drop_count <= drop_count + DROP_W'(1);
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    pack_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (word_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .drop_c    (drop_c)
    );

endmodule : toggle_sample_packer

// File: tb/tb_toggle_sample_packer.sv
// Scoreboard bench for toggle_sample_packer (WIDTH=8, EDGE_W=16, DROP_W=2).
module tb_toggle_sample_packer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned EDGE_W = 16;
    localparam int unsigned DROP_W = 2;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              sample_in;
    logic              sample_en;
    logic              out_ready;
    logic              clear_ovf;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [EDGE_W-1:0] edge_count;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [WIDTH-1:0] exp_q[$];

    toggle_sample_packer #(
        .WIDTH  (WIDTH),
        .EDGE_W (EDGE_W),
        .DROP_W (DROP_W)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .sample_in  (sample_in),
        .sample_en  (sample_en),
        .out_ready  (out_ready),
        .clear_ovf  (clear_ovf),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .edge_count (edge_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: every accepted word must match the oldest expected word
    always @(negedge clock) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(out_data), 32'hDEAD_BEEF);
            end else begin
                check("word", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic smp(input logic b);
        sample_en = 1'b1;
        sample_in = b;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic gap();
        sample_en = 1'b0;
        sample_in = 1'b0;
        tick();
    endtask

    task automatic feed_word(input logic [WIDTH-1:0] w, input bit expect_out);
        if (expect_out) exp_q.push_back(w);
        for (int i = 0; i < int'(WIDTH); i++) smp(w[i]);
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while (out_valid && k < 20) begin
            tick();
            k++;
        end
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clear();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] w;
        rst_n     = 1'b0;
        sample_in = 1'b0;
        sample_en = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_edges", 32'(edge_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        tick();

        // 1: alternating 0,1,... -> 0xAA one cycle after last sample, 4 edges
        out_ready = 1'b1;
        feed_word(8'hAA, 1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'hAA);
        check("t1_edges", 32'(edge_count), 32'd4);
        drain();

        // 2: backpressure, third word dropped
        out_ready = 1'b0;
        feed_word(8'hAA, 1'b1);
        feed_word(8'h0F, 1'b1);
        check("t2_head_before_drop", 32'(out_data), 32'hAA);
        feed_word(8'hFF, 1'b0);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_drops", 32'(drop_count), 32'd1);
        check("t2_head_held", 32'(out_data), 32'hAA);
        check("t2_edges", 32'(edge_count), 32'd9);
        drain();

        // 3: push and pop together while TWO is never a drop
        out_ready = 1'b0;
        pulse_clear();
        check("t3_clr_ovf", 32'(overflow), 32'd0);
        check("t3_clr_drops", 32'(drop_count), 32'd0);
        feed_word(8'h11, 1'b1);
        feed_word(8'h22, 1'b1);
        w = 8'h33;
        exp_q.push_back(w);
        for (int i = 0; i < int'(WIDTH) - 1; i++) smp(w[i]);
        out_ready = 1'b1;
        smp(w[WIDTH-1]);
        out_ready = 1'b0;
        check("t3_ovf", 32'(overflow), 32'd0);
        check("t3_drops", 32'(drop_count), 32'd0);
        check("t3_head", 32'(out_data), 32'h22);
        check("t3_edges", 32'(edge_count), 32'd14);
        drain();

        // 4: enable gaps with sample_in=0 in between must not be captured
        exp_q.push_back(8'hFF);
        for (int i = 0; i < int'(WIDTH); i++) begin
            smp(1'b1);
            if (i != int'(WIDTH) - 1) gap();
        end
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_data", 32'(out_data), 32'hFF);
        check("t4_edges", 32'(edge_count), 32'd15);
        drain();

        // 5: reset mid-word discards the partial word
        for (int i = 0; i < 5; i++) smp(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_data", 32'(out_data), 32'd0);
        check("t5_edges", 32'(edge_count), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        check("t5_drops", 32'(drop_count), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        feed_word(8'h5A, 1'b1);
        check("t5_clean_valid", 32'(out_valid), 32'd1);
        check("t5_clean_data", 32'(out_data), 32'h5A);
        check("t5_clean_edges", 32'(edge_count), 32'd3);
        drain();

        // 6: drop counter saturates at 3; drop beats a concurrent clear
        out_ready = 1'b0;
        feed_word(8'h01, 1'b1);
        feed_word(8'h02, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            feed_word(8'h03, 1'b0);
            check("t6_drops", 32'(drop_count), (k < 3) ? 32'(k) : 32'd3);
        end
        check("t6_ovf", 32'(overflow), 32'd1);
        w = 8'h04;
        for (int i = 0; i < int'(WIDTH) - 1; i++) smp(w[i]);
        clear_ovf = 1'b1;
        smp(w[WIDTH-1]);
        clear_ovf = 1'b0;
        check("t6_clr_drop_ovf", 32'(overflow), 32'd1);
        check("t6_clr_drop_cnt", 32'(drop_count), 32'd1);
        pulse_clear();
        check("t6_clr_ovf", 32'(overflow), 32'd0);
        check("t6_clr_cnt", 32'(drop_count), 32'd0);
        drain();

        // out_ready while empty does nothing
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_data", 32'(out_data), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_toggle_sample_packer

// File: doc/toggle_sample_packer.md
Name: toggle_sample_packer

Overview:
- Downstream consumer of the single-bit public register output of the free-running counter stage.
- Samples that bit each enabled cycle, packs WIDTH samples LSB-first into a word, and queues words in a 2-entry buffer.
- Words leave on a valid/ready stream.
- Also counts rising edges of the sampled bit and flags dropped words. It sits between the counter stage and any logging or bus consumer.

Parameters:
WIDTH, 8, samples per packed word (2..32)
EDGE_W, 16, width of rising-edge counter
DROP_W, 8, width of saturating drop counter

Ports:
clock  input  1  single clock, all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
sample_in  input  1  bit from upstream counter register
sample_en  input  1  sample sample_in this cycle
out_ready  input  1  consumer accepts head word
clear_ovf  input  1  clears overflow flag and drop_count
out_valid  output  1  buffer non-empty
out_data  output  WIDTH  head word of buffer
edge_count  output  EDGE_W  rising edges seen on sampled bit
overflow  output  1  sticky: at least one word dropped
drop_count  output  DROP_W  words dropped, saturating

Behaviour:
- Reset (rst_n low, asynchronous, any cycle): fill index 0, partial word 0, prev_sample 0, buffer EMPTY. out_valid 0, out_data 0, edge_count 0, overflow 0, drop_count 0. A partial word is discarded.
- Sampling, on posedge with sample_en=1:
  - Partial word bit[fill] <= sample_in.
  - fill increments; at fill==WIDTH-1 it wraps to 0 and the word is complete.
  - sample_en=0: nothing changes, including prev_sample and edge_count.
- Edge count, with sample_en=1: if prev_sample==0 and sample_in==1, edge_count++ (wraps modulo 2^EDGE_W). prev_sample <= sample_in.
- Completed word is {sample_in, partial[WIDTH-2:0]} and is offered for push on the same edge.
- Latency: when the buffer is EMPTY, out_valid=1 and out_data show the word in the cycle after the edge that captured the last sample.
- Buffer: 2 entries. The occupancy FSM has states EMPTY, ONE, TWO.
  - pop = out_valid && out_ready.
  - push = word complete.
  - EMPTY: push -> ONE.
  - ONE: push&&!pop -> TWO; pop&&!push -> EMPTY; push&&pop -> ONE with head = new word.
  - TWO: pop&&!push -> ONE; push&&pop -> TWO, FIFO order preserved; push&&!pop -> drop.
  - out_data is always the oldest entry. out_data holds stable while out_valid && !out_ready.
  - out_data is 0 when EMPTY.
- Drop (TWO, push, no pop):
  - New word discarded; buffer unchanged.
  - overflow <= 1.
  - drop_count increments, saturating at 2^DROP_W-1.
- clear_ovf: overflow <= 0 and drop_count <= 0.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Push when TWO and pop in the same cycle is never a drop.
- out_ready while EMPTY has no effect.

Decomposition:
- Shared package toggle_pack_pkg holds:
  - occupancy enum: OCC_EMPTY, OCC_ONE, OCC_TWO
  - default constants: WIDTH, EDGE_W, DROP_W
- One sub-module is natural: pack_fifo2, the 2-entry buffer with the occupancy FSM, push/pop and drop indication.
- Packing, the edge counter and the drop counter stay in the top module.

Test Plan:
1. Alternating input, WIDTH=8, sample_en=1:
   - Stimulus: sample_in 0,1,0,1,0,1,0,1 with out_ready=1.
   - Response: one cycle after the 8th sample, out_valid=1 and out_data=0xAA.
   - Response: edge_count=4.
2. Backpressure, out_ready=0, three words fed (0xAA, 0x0F, 0xFF):
   - Buffer holds 0xAA then 0x0F.
   - Third word is dropped; overflow=1, drop_count=1.
   - Raising out_ready yields 0xAA then 0x0F, then out_valid=0.
3. Simultaneous push+pop in TWO:
   - No drop, overflow stays 0.
   - Output order is old head, next, new word.
4. sample_en gaps:
   - Stimulus: 8 samples of 1 interleaved with sample_en=0 cycles.
   - Response: word 0xFF, edge_count +1 only.
   - Response: 0 samples are not captured during gaps.
5. Reset mid-word:
   - Stimulus: assert rst_n=0 after 5 samples.
   - Response: all outputs 0 immediately.
   - Response: the next 8 samples produce a clean word with no residue.
6. Saturation and clear, DROP_W=2:
   - Stimulus: force 5 drops.
   - Response: drop_count=3 and holds.
   - Response: clear_ovf with a concurrent drop gives overflow=1, drop_count=1.
